// File: rtl/instr_register_ctrl.sv
// Front-end controller for the 32-entry instruction register:
// round-robin write arbitration, FIFO pointers, two-cycle read-back.
package instr_register_pkg;
    typedef enum logic [3:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef logic [4:0] address_t;
    typedef logic signed [63:0] result_t;
    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  result;
    } instruction_t;
endpackage

module instr_register_ctrl
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_valid,
    output logic         a_ready,
    input  opcode_t      a_opcode,
    input  operand_t     a_operand_a,
    input  operand_t     a_operand_b,
    input  logic         b_valid,
    output logic         b_ready,
    input  opcode_t      b_opcode,
    input  operand_t     b_operand_a,
    input  operand_t     b_operand_b,
    input  logic         rd_req,
    output logic         rd_ack,
    output logic         rd_valid,
    output instruction_t rd_instruction,
    output logic         load_en,
    output address_t     write_pointer,
    output opcode_t      opcode,
    output operand_t     operand_a,
    output operand_t     operand_b,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic [5:0]   count,
    output logic         full,
    output logic         empty
);

    localparam logic [5:0] FULL_CNT = 6'(DEPTH);

    address_t wr_ptr;
    address_t rd_ptr;
    logic     rr_prio;
    logic     rd_pend;
    logic     grant;

    assign full  = (count == FULL_CNT);
    assign empty = (count == 6'd0);

    assign a_ready = a_valid & ~full & (~b_valid | ~rr_prio);
    assign b_ready = b_valid & ~full & (~a_valid | rr_prio);
    assign grant   = a_ready | b_ready;
    assign rd_ack  = rd_req & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            load_en        <= 1'b0;
            write_pointer  <= '0;
            read_pointer   <= '0;
            opcode         <= ZERO;
            operand_a      <= '0;
            operand_b      <= '0;
            rd_valid       <= 1'b0;
            rd_instruction <= '0;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            rr_prio        <= 1'b0;
            rd_pend        <= 1'b0;
        end else begin
            load_en  <= grant;
            rd_pend  <= rd_ack;
            rd_valid <= rd_pend;
            if (grant) begin
                write_pointer <= wr_ptr;
                wr_ptr        <= wr_ptr + 5'd1;
                rr_prio       <= a_ready;
                opcode        <= a_ready ? a_opcode    : b_opcode;
                operand_a     <= a_ready ? a_operand_a : b_operand_a;
                operand_b     <= a_ready ? a_operand_b : b_operand_b;
            end
            if (rd_ack) begin
                read_pointer <= rd_ptr;
                rd_ptr       <= rd_ptr + 5'd1;
            end
            // read_pointer settled last cycle, so the register output is stable now
            if (rd_pend)
                rd_instruction <= instruction_word;
            unique case ({grant, rd_ack})
                2'b10:   count <= count + 6'd1;
                2'b01:   count <= count - 6'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/instr_register_ctrl.md
# instr_register_ctrl

Front-end controller for the 32-entry instruction register. Arbitrates two write requesters (A, B) onto the register's single load port with round-robin priority. Manages the write and read pointers so the register behaves as a FIFO of instructions. Sequences read-back to a consumer with a fixed two-cycle latency, and reports occupancy status.

## Interface
Parameters:
- DEPTH, 32, number of instruction register entries; must equal 2**$bits(address_t).

Ports (types from instr_register_pkg: opcode_t, operand_t signed, address_t 5-bit, instruction_t):
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- a_valid  in  1  requester A has an instruction
- a_ready  out  1  A's instruction is accepted this cycle
- a_opcode / a_operand_a / a_operand_b  in  opcode_t / operand_t / operand_t  A payload
- b_valid, b_ready, b_opcode, b_operand_a, b_operand_b  as for A
- rd_req  in  1  consumer requests the oldest entry
- rd_ack  out  1  read request accepted this cycle
- rd_valid  out  1  rd_instruction is valid (one-cycle pulse per accepted read)
- rd_instruction  out  instruction_t  entry read back, including the result field
- load_en  out  1  to instruction register
- write_pointer  out  address_t  to instruction register
- opcode  out  opcode_t  to instruction register
- operand_a, operand_b  out  operand_t  to instruction register
- read_pointer  out  address_t  to instruction register
- instruction_word  in  instruction_t  from instruction register, combinational read of iw_reg[read_pointer]
- count  out  6  occupied entries, 0..32
- full / empty  out  1  count==32 / count==0

## Operation
- Internal state: wr_ptr (5-bit), rd_ptr (5-bit), count (6-bit), rr_prio (0=A preferred, 1=B preferred), rd_pend (1-bit).
- Arbitration:
  - a_ready = a_valid & !full & (!b_valid | rr_prio==0).
  - b_ready = b_valid & !full & (!a_valid | rr_prio==1).
  - The ready signals are combinational; at most one is high.
- Requester protocol: a requester holds its payload stable while valid is high and ready is low.
- Write grant, cycle N:
  - The granted payload is registered onto opcode/operand_a/operand_b with write_pointer<=wr_ptr and load_en<=1, all visible in N+1.
  - wr_ptr increments and rr_prio becomes the opposite of the granted side.
  - With no grant, load_en<=0 and the payload outputs hold their previous values.
- Read accept: rd_ack = rd_req & !empty (combinational). On an accept in cycle N:
  - read_pointer<=rd_ptr (visible N+1); rd_ptr increments; rd_pend<=1.
  - In N+1, instruction_word is registered into rd_instruction, and rd_valid=1 in N+2.
- count:
  - +1 on grant only; -1 on rd_ack only.
  - Unchanged when a grant and an rd_ack occur in the same cycle.
- Pointers wrap 31→0 with no special handling.
- The result field is never written by this block; it is returned exactly as the instruction register supplies it.

## Timing
- Reset values:
  - load_en=0, write_pointer=0, read_pointer=0.
  - opcode=ZERO, operand_a=0, operand_b=0.
  - rd_valid=0, rd_instruction=0.
  - count=0, empty=1, full=0.
  - wr_ptr=rd_ptr=0, rr_prio=0, rd_pend=0.
- Reset dominates all other inputs in the same cycle.
- Mid-operation reset:
  - Any in-flight read is dropped, and rd_valid is 0 in the cycle after reset.
  - Instruction register contents are not cleared but are treated as empty.
- Write latency: grant in N → load_en high in N+1 → data stored at the end of N+1.
- Read latency: rd_ack in N → rd_valid in N+2.
- Write-to-read: an entry granted in N is counted at N+1.
  - rd_ack is possible in N+1 at the earliest, and the read returns the new data.
  - There is no bypass when empty: rd_ack=0 in the grant cycle.
- Full: both readies are 0, but rd_ack is still allowed. A read and a write in the same cycle at full is not possible; the write waits one cycle.
- Empty: rd_ack=0. rd_req is level-sensitive, and the consumer keeps it asserted until acknowledged.
- Throughput: one write and one read per cycle sustained. Back-to-back rd_ack produces consecutive rd_valid pulses.

## Test plan
- Reset then idle:
  - All outputs hold reset values, empty=1.
  - Assert rd_req for 5 cycles → rd_ack=0, rd_valid=0 throughout.
- A alone writes 3 instructions (ADD 5,3; SUB -7,2; MULT 4,4) back-to-back:
  - write_pointer 0,1,2 with load_en high for 3 cycles; count=3.
  - Reading 3 times returns them in order, with result fields 8, -9, 16; each rd_valid follows its rd_ack by 2 cycles.
- A and B valid continuously:
  - Grants alternate A,B,A,B starting with A after reset; no starvation.
  - B alone for 2 cycles, then both valid → A granted next.
- Fill to 32 entries:
  - full=1, a_ready=b_ready=0 while valid.
  - One rd_ack → count=31, and the next cycle a grant lands at write_pointer=0 (wrap).
  - Read all 32 → read_pointer wraps 31→0, empty=1.
- Simultaneous grant and rd_ack with count=10 → count stays 10, and both pointers advance by 1.
- Reset asserted in the cycle after rd_ack → no rd_valid pulse; count=0; the next write lands at write_pointer=0.
